// File: rtl/rst_sequencer.sv
// rst_sequencer
// Board-level reset sequencer. Pulses the PLL reset, waits for a filtered and
// time-limited PLL lock, then releases NUM_OUT active-low domain resets one at
// a time, bit 0 first. Handles lock-timeout retries, a terminal fault state,
// software restarts and loss of lock.
//
// Optional feature: define RSTSEQ_AUTORECOVER_EN to restart the sequence when
// lock drops in STAGE or RUN. Without it, a lock drop only sets LockLost.
//
// Ports:
//   CLK        in   system clock
//   ExtRESET   in   synchronous active-high reset, highest priority
//   PllLocked  in   asynchronous PLL lock, double-flop synchronised here
//   SwReset    in   single-cycle restart request (ignored in FAULT)
//   PllRESETn  out  active-low PLL reset
//   RstnOut    out  [NUM_OUT] active-low domain resets, bit 0 released first
//   Ready      out  all channels released, sequencer in RUN
//   Fault      out  lock retries exhausted
//   LockLost   out  sticky: synced lock fell while in STAGE or RUN
//   RetryCnt   out  [4] lock retries consumed in the current sequence
module rst_sequencer #(
  parameter int NUM_OUT      = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_FILT    = 8,
  parameter int STAGE_DLY    = 32,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic               CLK,
  input  logic               ExtRESET,
  input  logic               PllLocked,
  input  logic               SwReset,
  output logic               PllRESETn,
  output logic [NUM_OUT-1:0] RstnOut,
  output logic               Ready,
  output logic               Fault,
  output logic               LockLost,
  output logic [3:0]         RetryCnt
);

  typedef enum logic [2:0] {PLLRST, WAITLOCK, STAGE, RUN, FAULT} state_t;

  localparam int PW = $clog2(PLL_RST_CYC + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STAGE_DLY + 1);
  localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [PW-1:0] PLL_END   = PW'(PLL_RST_CYC);
  localparam logic [FW-1:0] FILT_END  = FW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STG_END   = SW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_END   = IW'(NUM_OUT - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  state_t              state, state_n;
  logic [PW-1:0]       pll_cnt, pll_cnt_n;
  logic [FW-1:0]       filt_cnt, filt_n;
  logic [TW-1:0]       tmo_cnt, tmo_n;
  logic [SW-1:0]       stg_cnt, stg_n;
  logic [IW-1:0]       idx, idx_n;
  logic [1:0]          sync_pipe;
  logic                lock_s;
  logic [NUM_OUT-1:0]  rstn_n;
  logic [3:0]          retry_n;
  logic                lost_n, lock_drop, recover, go_pll;

  assign lock_s = sync_pipe[1];

  always_comb begin
    state_n   = state;
    pll_cnt_n = pll_cnt;
    filt_n    = filt_cnt;
    tmo_n     = tmo_cnt;
    stg_n     = stg_cnt;
    idx_n     = idx;
    rstn_n    = RstnOut;
    retry_n   = RetryCnt;
    lost_n    = LockLost;
    go_pll    = 1'b0;
    recover   = 1'b0;
    // STAGE/RUN are only entered with lock high, so a low level here is a fall.
    lock_drop = ((state == STAGE) || (state == RUN)) && !lock_s;

    if (SwReset && (state != FAULT)) begin
      go_pll  = 1'b1;
      retry_n = '0;
    end else begin
      if (lock_drop) lost_n = 1'b1;
`ifdef RSTSEQ_AUTORECOVER_EN
      recover = lock_drop;
`endif
      if (recover) begin
        go_pll = 1'b1;
      end else begin
        case (state)
          PLLRST: begin
            if (pll_cnt == PLL_END) begin
              state_n = WAITLOCK;
              filt_n  = '0;
              tmo_n   = '0;
            end else begin
              pll_cnt_n = pll_cnt + 1'b1;
            end
          end
          WAITLOCK: begin
            filt_n = lock_s ? filt_cnt + 1'b1 : '0;
            tmo_n  = tmo_cnt + 1'b1;
            // Lock acceptance is checked first so it wins a same-cycle timeout.
            if (lock_s && (filt_cnt == FILT_END)) begin
              state_n = STAGE;
              stg_n   = '0;
              idx_n   = '0;
            end else if (tmo_cnt == TMO_END) begin
              if (RetryCnt < RETRY_MAX) begin
                retry_n = RetryCnt + 1'b1;
                go_pll  = 1'b1;
              end else begin
                state_n = FAULT;
              end
            end
          end
          STAGE: begin
            if (stg_cnt == STG_END) begin
              stg_n = '0;
              for (int k = 0; k < NUM_OUT; k++)
                if (idx == IW'(k)) rstn_n[k] = 1'b1;
              if (idx == IDX_END) begin
                state_n = RUN;
                retry_n = '0;
              end else begin
                idx_n = idx + 1'b1;
              end
            end else begin
              stg_n = stg_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // The restart edge is itself the first low cycle of the PLL pulse, so the
    // pulse counter starts at 1 and PllRESETn rises PLL_RST_CYC edges later.
    if (go_pll) begin
      state_n   = PLLRST;
      pll_cnt_n = PW'(1);
      filt_n    = '0;
      tmo_n     = '0;
      stg_n     = '0;
      idx_n     = '0;
      rstn_n    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (ExtRESET) begin
      state     <= PLLRST;
      pll_cnt   <= '0;
      filt_cnt  <= '0;
      tmo_cnt   <= '0;
      stg_cnt   <= '0;
      idx       <= '0;
      sync_pipe <= '0;
      PllRESETn <= 1'b0;
      RstnOut   <= '0;
      Ready     <= 1'b0;
      Fault     <= 1'b0;
      LockLost  <= 1'b0;
      RetryCnt  <= '0;
    end else begin
      state     <= state_n;
      pll_cnt   <= pll_cnt_n;
      filt_cnt  <= filt_n;
      tmo_cnt   <= tmo_n;
      stg_cnt   <= stg_n;
      idx       <= idx_n;
      sync_pipe <= {sync_pipe[0], PllLocked};
      PllRESETn <= (state_n == WAITLOCK) || (state_n == STAGE) || (state_n == RUN);
      RstnOut   <= rstn_n;
      Ready     <= (state_n == RUN);
      Fault     <= (state_n == FAULT);
      LockLost  <= lost_n;
      RetryCnt  <= retry_n;
    end
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised successor to the two-output reset generator. It drives the PLL reset, waits for a filtered and time-limited PLL lock, then releases NUM_OUT downstream reset lines in a staggered order. It also handles lock-timeout retries, a hard fault state, software-requested restarts and lock-loss recovery. It sits at the top of the design between the board reset/PLL and every function-generator domain.

## Interface
- NUM_OUT, 4, number of staged active-low reset outputs (1..16)
- PLL_RST_CYC, 16, PllRESETn low-pulse length in cycles after reset release (≥2)
- LOCK_FILT, 8, consecutive synced-lock-high cycles required to accept lock (≥1)
- STAGE_DLY, 32, cycles between successive channel releases (≥1)
- LOCK_TIMEOUT, 4096, WAITLOCK cycles before a retry (> LOCK_FILT)
- MAX_RETRY, 3, retries before FAULT (0..15)

Ports:
- CLK  in  1  system clock (27 MHz nominal)
- ExtRESET  in  1  synchronous, active-high reset; highest priority
- PllLocked  in  1  asynchronous PLL lock; 2-flop synchroniser inside
- SwReset  in  1  single-cycle restart request
- PllRESETn  out  1  active-low PLL reset
- RstnOut  out  NUM_OUT  active-low domain resets; bit 0 released first
- Ready  out  1  all channels released, state RUN
- Fault  out  1  retries exhausted
- LockLost  out  1  sticky: synced lock fell while in STAGE or RUN
- RetryCnt  out  4  retries consumed in the current sequence

## Operation
- States: PLLRST, WAITLOCK, STAGE, RUN, FAULT. All outputs are registered.
- ExtRESET=1: state PLLRST, all counters 0, sync flops 0. PllRESETn=0, RstnOut=0, Ready=0, Fault=0, LockLost=0, RetryCnt=0.
- PLLRST: PllRESETn=0, RstnOut=0. Counter runs for PLL_RST_CYC cycles, then the block enters WAITLOCK and drives PllRESETn=1.
- WAITLOCK:
  - Filter counter +1 while synced lock=1; it clears to 0 when synced lock=0.
  - Filter reaching LOCK_FILT → STAGE.
  - Timeout counter reaching LOCK_TIMEOUT first → if RetryCnt<MAX_RETRY, RetryCnt+1 and go to PLLRST; otherwise go to FAULT.
  - If both events occur in the same cycle, lock wins.
- STAGE: bit k of RstnOut goes 1 exactly STAGE_DLY·(k+1) cycles after STAGE entry. The last release moves to RUN, sets Ready=1 and clears RetryCnt, all on that same edge.
- RUN: holds until lock loss, SwReset or ExtRESET.
- FAULT: PllRESETn=0, RstnOut=0, Ready=0, Fault=1. SwReset is ignored. Only ExtRESET exits.
- SwReset=1 in any state other than FAULT → PLLRST on the next edge. RetryCnt is cleared, counters are cleared, RstnOut=0 and Ready=0. LockLost is kept.
- Lock loss (synced lock 1→0 in STAGE/RUN) sets LockLost and is handled per Configuration.
- Priority: ExtRESET > SwReset > lock loss > internal transitions.

## Timing
- t0 is the first edge at which ExtRESET samples 0.
- PllRESETn rises at t0+PLL_RST_CYC.
- With synced lock already 1, STAGE is entered at t0+PLL_RST_CYC+LOCK_FILT.
- PllLocked-to-internal latency is 2 cycles.
- Any restart (SwReset, lock-loss recovery) drives RstnOut=0 and Ready=0 on the edge after the triggering sample.
- Outputs never glitch: every change of RstnOut, Ready and PllRESETn happens on a CLK edge.

## Configuration
- RSTSEQ_AUTORECOVER_EN defined: lock loss in STAGE or RUN → PLLRST on the next edge. RstnOut=0, Ready=0, RetryCnt unchanged, LockLost=1.
- Not defined: lock loss only sets LockLost. STAGE releases continue, and RUN outputs and Ready remain unchanged.

## Test plan
- Defaults, PllLocked=1 throughout, ExtRESET dropped at t0 → PllRESETn↑ at t0+16; STAGE entered at t0+24; RstnOut[0..3]↑ at t0+56/88/120/152; Ready↑ at t0+152.
- PllLocked never asserts → three retries, RetryCnt steps 1,2,3, PllRESETn pulses low 16 cycles per retry. Fourth timeout → Fault=1 with all outputs low. SwReset is ignored; ExtRESET clears Fault.
- PllLocked toggles every 5 cycles for 100 cycles, then stays high → no STAGE entry during the toggling; STAGE is entered 10 cycles (2 sync + 8 filter) after the final rise.
- Lock dropped in RUN, macro defined → next edge after synced fall: RstnOut=0, Ready=0, LockLost=1; the full sequence repeats. Macro undefined → only LockLost=1.
- SwReset pulsed mid-STAGE after RstnOut[1:0]=11 → RstnOut=0000 on the next edge, PllRESETn low for 16 cycles, then the normal sequence.
- ExtRESET asserted in RUN and held 3 cycles → all outputs reach their reset values on the first edge it is sampled high.
